mem_bridge: RTL and testbench
=============================

# mem_bridge

Memory-side bridge directly downstream of the CPU core. It accepts the core's level-signalled data reads, data writes and 32-bit instruction fetches, and sequences them as 16-bit transactions on a simple request/acknowledge SDRAM-controller port. It returns data and instructions to the core and drives the core's busy/ready/cack handshake.

## Interface
Parameters:
- ADDR_W, 20, core word-address width.
- SD_ADDR_W, 22, backend address width: {space bit, ADDR_W address, half bit}.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- addr  in  20  request word address from the core
- wdata  in  16  write data from the core
- ram_read  in  1  read request (level)
- ram_write  in  1  write request (level)
- ram_instr_access  in  1  request targets instruction space; with ram_read, it is a 32-bit fetch
- ram_read_done  in  1  core has consumed data-read result
- mem_rdata  out  16  data-read result
- instr  out  32  fetched instruction
- mem_busy  out  1  transaction in progress
- mem_ready  out  1  result valid / write complete
- mem_cack  out  1  one-cycle pulse: request accepted
- sd_addr  out  22  backend address
- sd_req  out  1  backend command request, held until sd_ack
- sd_we  out  1  backend write enable, qualified by sd_req
- sd_wdata  out  16  backend write data
- sd_ack  in  1  backend accepted command (1-cycle pulse)
- sd_rdata  in  16  backend read data
- sd_rvalid  in  1  sd_rdata valid (1-cycle pulse)

## Operation
- States: IDLE, WR, RD, IF_LO, IF_HI, HOLD.
- IDLE: sample requests. If ram_write is high, go to WR. Write wins over a simultaneous ram_read; the read is still pending and is taken after the write completes. Else if ram_read is high, go to IF_LO when ram_instr_access=1, otherwise RD. addr, wdata and the space bit are latched at acceptance.
- Acceptance registers mem_cack=1 (one cycle), mem_busy=1 and sd_req=1.
- sd_addr = {space, latched addr, half}. half=0 for data and the low instruction word; half=1 for the high instruction word.
- WR: sd_we=1, sd_wdata=latched wdata. On sd_ack, drop sd_req and pulse mem_ready for 1 cycle with mem_busy=0, then return to IDLE.
- RD: on sd_ack, drop sd_req. On sd_rvalid, latch mem_rdata and go to HOLD.
- IF_LO: on sd_rvalid, latch instr[15:0], re-assert sd_req with half=1, and go to IF_HI.
- IF_HI: on sd_rvalid, latch instr[31:16] and go to HOLD.
- HOLD: mem_ready=1, mem_busy=0, result held stable. Leave when ram_read_done=1 or ram_read=0 is sampled, then return to IDLE.
- sd_ack and sd_rvalid arriving in the same cycle are both honoured.
- sd_rvalid in any state other than RD, IF_LO or IF_HI is ignored.
- An address of all ones still maps correctly: the half bit is separate, so there is no carry into the space bit.
- Request inputs changing after acceptance are ignored until IDLE.

## Timing
- Reset values: all outputs 0, mem_rdata=0, instr=0, state IDLE.
- Reset mid-transaction drops sd_req on the next edge and abandons the backend transaction. The backend must tolerate a withdrawn request.
- Request sampled in IDLE at cycle N: mem_cack, mem_busy and sd_req are high at N+1.
- sd_ack at cycle A: sd_req is low at A+1.
- Write: mem_ready is high during A+1 only.
- Read: sd_rvalid at cycle R gives mem_ready and data at R+1.
- Fetch: low sd_rvalid at R1 gives second sd_req at R1+1. High sd_rvalid at R2 gives mem_ready at R2+1.
- Release sampled at cycle H: mem_ready=0 at H+1, state IDLE. The earliest next acceptance sample is H+1, so cack is at H+2.
- Minimum latency with zero-wait backend (ack and rvalid in the first sd_req cycle): read 2 cycles from acceptance, fetch 3 cycles.

## Structure
- Shared package holds the state enum, ADDR_W/SD_ADDR_W defaults and the half-bit/space-bit position constants.
- No sub-module. A single FSM plus latched address and data registers; roughly 150–250 lines.

## Test plan
- Data write addr=0x00012, wdata=0xBEEF, ack after 2 cycles -> sd_addr=0x000024, sd_we=1, sd_wdata=0xBEEF, one mem_ready pulse, busy low afterward.
- Data read addr=0xFFFFF, rdata=0x1234 after 3 cycles -> sd_addr=0x1FFFFE, mem_rdata=0x1234 held with ready until ram_read_done, then ready=0.
- Fetch addr=0x00100 with instr_access, backend returns 0x0041 then 0xABCD -> sd_addr 0x200200 then 0x200201, instr=0xABCD0041.
- Simultaneous ram_read and ram_write -> write serviced first (sd_we=1), then read accepted with a second cack.
- Zero-wait backend (ack+rvalid same cycle) on read and fetch -> ready at acceptance+2 and +3 respectively. A spurious rvalid in IDLE changes nothing.
- rst asserted during IF_HI with sd_req high -> next cycle all outputs 0 and IDLE. A new read afterward completes normally.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared constants for the CPU-side memory bridge: widths, FSM state codes
// and the bit positions of the half/space bits in the backend address.
package mem_bridge_pkg;

    localparam int ADDR_W_DEF    = 20;
    localparam int SD_ADDR_W_DEF = 22;
    localparam int DATA_W        = 16;
    localparam int INSTR_W       = 32;

    // Half-word select occupies the backend address LSB.
    localparam int HALF_BIT = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WR    = 3'd1;
    localparam state_t ST_RD    = 3'd2;
    localparam state_t ST_IF_LO = 3'd3;
    localparam state_t ST_IF_HI = 3'd4;
    localparam state_t ST_HOLD  = 3'd5;

    // Space bit sits directly above the word address, which sits above the half bit.
    function automatic int space_bit_pos(input int addr_w);
        return addr_w + HALF_BIT + 1;
    endfunction

endpackage

// File: rtl/mem_bridge.sv
// Bridge between the CPU core's level-signalled memory requests and a
// 16-bit request/acknowledge SDRAM-controller port. 32-bit instruction
// fetches are split into two 16-bit backend reads (low half first).
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int SD_ADDR_W = SD_ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 ram_read,
    input  logic                 ram_write,
    input  logic                 ram_instr_access,
    input  logic                 ram_read_done,
    output logic [DATA_W-1:0]    mem_rdata,
    output logic [INSTR_W-1:0]   instr,
    output logic                 mem_busy,
    output logic                 mem_ready,
    output logic                 mem_cack,
    output logic [SD_ADDR_W-1:0] sd_addr,
    output logic                 sd_req,
    output logic                 sd_we,
    output logic [DATA_W-1:0]    sd_wdata,
    input  logic                 sd_ack,
    input  logic [DATA_W-1:0]    sd_rdata,
    input  logic                 sd_rvalid
);

    localparam int SPACE_BIT = space_bit_pos(ADDR_W);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 space_q, space_d;
    logic                 half_q, half_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic                 cack_q, cack_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [SD_ADDR_W-1:0] sd_addr_s;

    // Next-state and datapath update for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        space_d = space_q;
        half_d  = half_q;
        req_d   = req_q;
        we_d    = we_q;
        cack_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        instr_d = instr_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b0;
                if (ram_write) begin
                    // Write has priority; a concurrent read stays pending on the level input.
                    state_d = ST_WR;
                    addr_d  = addr;
                    wdata_d = wdata;
                    space_d = ram_instr_access;
                    half_d  = 1'b0;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    cack_d  = 1'b1;
                    busy_d  = 1'b1;
                end else if (ram_read) begin
                    state_d = ram_instr_access ? ST_IF_LO : ST_RD;
                    addr_d  = addr;
                    space_d = ram_instr_access;
                    half_d  = 1'b0;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    cack_d  = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WR: begin
                if (req_q) begin
                    if (sd_ack) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        req_d = 1'b1;
                    end
                end else begin
                    // Ready-pulse cycle: the core sees completion and can drop ram_write
                    // before IDLE samples the request lines again.
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_RD: begin
                if (sd_ack) begin
                    req_d = 1'b0;
                end else begin
                    req_d = req_q;
                end
                if (sd_rvalid) begin
                    rdata_d = sd_rdata;
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RD;
                end
            end

            ST_IF_LO: begin
                if (sd_ack) begin
                    req_d = 1'b0;
                end else begin
                    req_d = req_q;
                end
                if (sd_rvalid) begin
                    // Low half arrived: immediately issue the high-half request.
                    instr_d[DATA_W-1:0] = sd_rdata;
                    req_d   = 1'b1;
                    half_d  = 1'b1;
                    state_d = ST_IF_HI;
                end else begin
                    state_d = ST_IF_LO;
                end
            end

            ST_IF_HI: begin
                if (sd_ack) begin
                    req_d = 1'b0;
                end else begin
                    req_d = req_q;
                end
                if (sd_rvalid) begin
                    instr_d[INSTR_W-1:DATA_W] = sd_rdata;
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IF_HI;
                end
            end

            ST_HOLD: begin
                if (ram_read_done || !ram_read) begin
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            space_q <= 1'b0;
            half_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            cack_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            space_q <= space_d;
            half_q  <= half_d;
            req_q   <= req_d;
            we_q    <= we_d;
            cack_q  <= cack_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            instr_q <= instr_d;
        end
    end

    // Backend address assembly; the half bit is its own field, so no carry reaches the space bit.
    always_comb begin
        sd_addr_s                            = '0;
        sd_addr_s[HALF_BIT]                  = half_q;
        sd_addr_s[HALF_BIT+ADDR_W:HALF_BIT+1] = addr_q;
        sd_addr_s[SPACE_BIT]                 = space_q;
    end

    assign sd_addr   = sd_addr_s;
    assign sd_req    = req_q;
    assign sd_we     = we_q;
    assign sd_wdata  = wdata_q;
    assign mem_cack  = cack_q;
    assign mem_busy  = busy_q;
    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign instr     = instr_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        ram_read;
    logic        ram_write;
    logic        ram_instr_access;
    logic        ram_read_done;
    logic [15:0] mem_rdata;
    logic [31:0] instr;
    logic        mem_busy;
    logic        mem_ready;
    logic        mem_cack;
    logic [21:0] sd_addr;
    logic        sd_req;
    logic        sd_we;
    logic [15:0] sd_wdata;
    logic        sd_ack;
    logic [15:0] sd_rdata;
    logic        sd_rvalid;

    int n_cmp = 0;
    int n_err = 0;

    mem_bridge dut (
        .clk              (clk),
        .rst              (rst),
        .addr             (addr),
        .wdata            (wdata),
        .ram_read         (ram_read),
        .ram_write        (ram_write),
        .ram_instr_access (ram_instr_access),
        .ram_read_done    (ram_read_done),
        .mem_rdata        (mem_rdata),
        .instr            (instr),
        .mem_busy         (mem_busy),
        .mem_ready        (mem_ready),
        .mem_cack         (mem_cack),
        .sd_addr          (sd_addr),
        .sd_req           (sd_req),
        .sd_we            (sd_we),
        .sd_wdata         (sd_wdata),
        .sd_ack           (sd_ack),
        .sd_rdata         (sd_rdata),
        .sd_rvalid        (sd_rvalid)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Advance one clock edge, then settle so registered outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        rst = 1'b1; addr = 20'h0; wdata = 16'h0; ram_read = 1'b0; ram_write = 1'b0;
        ram_instr_access = 1'b0; ram_read_done = 1'b0;
        sd_ack = 1'b0; sd_rdata = 16'h0; sd_rvalid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_req",   {31'd0, sd_req},    32'd0);
        chk("rst_busy",  {31'd0, mem_busy},  32'd0);
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_cack",  {31'd0, mem_cack},  32'd0);
        chk("rst_we",    {31'd0, sd_we},     32'd0);
        chk("rst_addr",  {10'd0, sd_addr},   32'd0);
        chk("rst_rdata", {16'd0, mem_rdata}, 32'd0);
        chk("rst_instr", instr,              32'd0);

        // Data write 0x00012 <- 0xBEEF, ack two cycles after cack
        addr = 20'h00012; wdata = 16'hBEEF; ram_write = 1'b1;
        tick();
        chk("wr_cack",   {31'd0, mem_cack}, 32'd1);
        chk("wr_busy",   {31'd0, mem_busy}, 32'd1);
        chk("wr_req",    {31'd0, sd_req},   32'd1);
        chk("wr_we",     {31'd0, sd_we},    32'd1);
        chk("wr_addr",   {10'd0, sd_addr},  32'h000024);
        chk("wr_wdata",  {16'd0, sd_wdata}, 32'h0000BEEF);
        tick();
        chk("wr_cack_pulse", {31'd0, mem_cack}, 32'd0);
        chk("wr_req_hold",   {31'd0, sd_req},   32'd1);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        chk("wr_req_drop", {31'd0, sd_req},    32'd0);
        chk("wr_ready",    {31'd0, mem_ready}, 32'd1);
        chk("wr_busy_lo",  {31'd0, mem_busy},  32'd0);
        ram_write = 1'b0;
        tick();
        chk("wr_ready_pulse", {31'd0, mem_ready}, 32'd0);
        chk("wr_busy_after",  {31'd0, mem_busy},  32'd0);
        tick();
        chk("wr_no_reaccept", {31'd0, mem_cack}, 32'd0);

        // Data read from all-ones address, ack then rvalid 0x1234
        addr = 20'hFFFFF; ram_read = 1'b1;
        tick();
        chk("rd_cack", {31'd0, mem_cack}, 32'd1);
        chk("rd_addr", {10'd0, sd_addr},  32'h1FFFFE);
        chk("rd_we",   {31'd0, sd_we},    32'd0);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        chk("rd_req_drop", {31'd0, sd_req},    32'd0);
        chk("rd_not_rdy",  {31'd0, mem_ready}, 32'd0);
        tick();
        sd_rvalid = 1'b1; sd_rdata = 16'h1234;
        tick();
        sd_rvalid = 1'b0; sd_rdata = 16'hDEAD;
        chk("rd_ready", {31'd0, mem_ready}, 32'd1);
        chk("rd_data",  {16'd0, mem_rdata}, 32'h00001234);
        chk("rd_busy",  {31'd0, mem_busy},  32'd0);
        sd_rvalid = 1'b1;
        tick();
        sd_rvalid = 1'b0;
        tick();
        chk("rd_hold_ready", {31'd0, mem_ready}, 32'd1);
        chk("rd_hold_data",  {16'd0, mem_rdata}, 32'h00001234);
        ram_read_done = 1'b1;
        tick();
        ram_read_done = 1'b0; ram_read = 1'b0;
        chk("rd_release", {31'd0, mem_ready}, 32'd0);

        // Instruction fetch 0x00100 -> 0x0041 then 0xABCD
        addr = 20'h00100; ram_instr_access = 1'b1; ram_read = 1'b1;
        tick();
        chk("if_cack",   {31'd0, mem_cack}, 32'd1);
        chk("if_addr_lo", {10'd0, sd_addr}, 32'h200200);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        chk("if_req_drop", {31'd0, sd_req}, 32'd0);
        sd_rvalid = 1'b1; sd_rdata = 16'h0041;
        tick();
        sd_rvalid = 1'b0;
        chk("if_req_hi",   {31'd0, sd_req},    32'd1);
        chk("if_addr_hi",  {10'd0, sd_addr},   32'h200201);
        chk("if_busy_mid", {31'd0, mem_busy},  32'd1);
        chk("if_rdy_mid",  {31'd0, mem_ready}, 32'd0);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        sd_rvalid = 1'b1; sd_rdata = 16'hABCD;
        tick();
        sd_rvalid = 1'b0;
        chk("if_ready", {31'd0, mem_ready}, 32'd1);
        chk("if_instr", instr,              32'hABCD0041);
        ram_read = 1'b0; ram_instr_access = 1'b0;
        tick();
        chk("if_release", {31'd0, mem_ready}, 32'd0);

        // Simultaneous write and read: write first, read afterwards (zero-wait)
        addr = 20'h00005; wdata = 16'h5A5A; ram_write = 1'b1; ram_read = 1'b1;
        tick();
        chk("sim_cack1", {31'd0, mem_cack}, 32'd1);
        chk("sim_we",    {31'd0, sd_we},    32'd1);
        chk("sim_addr",  {10'd0, sd_addr},  32'h00000A);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        chk("sim_wr_ready", {31'd0, mem_ready}, 32'd1);
        ram_write = 1'b0;
        tick();
        chk("sim_gap_cack", {31'd0, mem_cack}, 32'd0);
        tick();
        chk("sim_cack2",  {31'd0, mem_cack}, 32'd1);
        chk("sim_rd_we",  {31'd0, sd_we},    32'd0);
        chk("sim_rd_req", {31'd0, sd_req},   32'd1);
        sd_ack = 1'b1; sd_rvalid = 1'b1; sd_rdata = 16'h7777;
        tick();
        sd_ack = 1'b0; sd_rvalid = 1'b0;
        chk("zw_rd_ready", {31'd0, mem_ready}, 32'd1);
        chk("zw_rd_data",  {16'd0, mem_rdata}, 32'h00007777);
        ram_read = 1'b0;
        tick();
        chk("zw_rd_release", {31'd0, mem_ready}, 32'd0);

        // Zero-wait fetch: ready at acceptance + 3
        addr = 20'h00003; ram_instr_access = 1'b1; ram_read = 1'b1;
        tick();
        chk("zw_if_addr", {10'd0, sd_addr}, 32'h200006);
        sd_ack = 1'b1; sd_rvalid = 1'b1; sd_rdata = 16'h1111;
        tick();
        chk("zw_if_mid_rdy",  {31'd0, mem_ready}, 32'd0);
        chk("zw_if_mid_req",  {31'd0, sd_req},    32'd1);
        chk("zw_if_mid_addr", {10'd0, sd_addr},   32'h200007);
        sd_rdata = 16'h2222;
        tick();
        sd_ack = 1'b0; sd_rvalid = 1'b0;
        chk("zw_if_ready", {31'd0, mem_ready}, 32'd1);
        chk("zw_if_instr", instr,              32'h22221111);
        ram_read = 1'b0; ram_instr_access = 1'b0;
        tick();
        chk("zw_if_release", {31'd0, mem_ready}, 32'd0);

        // Spurious rvalid in IDLE
        sd_rvalid = 1'b1; sd_rdata = 16'hFFFF;
        tick();
        sd_rvalid = 1'b0;
        chk("sp_rdata", {16'd0, mem_rdata}, 32'h00007777);
        chk("sp_instr", instr,              32'h22221111);
        chk("sp_ready", {31'd0, mem_ready}, 32'd0);
        chk("sp_busy",  {31'd0, mem_busy},  32'd0);
        chk("sp_req",   {31'd0, sd_req},    32'd0);

        // Reset during IF_HI with sd_req high
        addr = 20'h00010; ram_instr_access = 1'b1; ram_read = 1'b1;
        tick();
        sd_rvalid = 1'b1; sd_rdata = 16'h0001;
        tick();
        sd_rvalid = 1'b0;
        chk("rst_if_hi_req", {31'd0, sd_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; ram_read = 1'b0; ram_instr_access = 1'b0;
        chk("mrst_req",   {31'd0, sd_req},    32'd0);
        chk("mrst_busy",  {31'd0, mem_busy},  32'd0);
        chk("mrst_ready", {31'd0, mem_ready}, 32'd0);
        chk("mrst_cack",  {31'd0, mem_cack},  32'd0);
        chk("mrst_addr",  {10'd0, sd_addr},   32'd0);
        chk("mrst_instr", instr,              32'd0);
        chk("mrst_rdata", {16'd0, mem_rdata}, 32'd0);

        // Read after reset completes normally
        addr = 20'h00020; ram_read = 1'b1;
        tick();
        chk("post_cack", {31'd0, mem_cack}, 32'd1);
        chk("post_addr", {10'd0, sd_addr},  32'h000040);
        sd_ack = 1'b1; sd_rvalid = 1'b1; sd_rdata = 16'h4242;
        tick();
        sd_ack = 1'b0; sd_rvalid = 1'b0;
        chk("post_ready", {31'd0, mem_ready}, 32'd1);
        chk("post_data",  {16'd0, mem_rdata}, 32'h00004242);
        ram_read = 1'b0;
        tick();
        chk("post_release", {31'd0, mem_ready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
